// File: rtl/alu_pipe_fu.sv
// Pipelined integer ALU functional unit: operands are evaluated at issue, then
// carried with their destination tag through STAGES valid/ready-handshaked registers.
module alu_pipe_fu #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 6
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         squash,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_func,
  input  logic [XLEN-1:0]              in_opa,
  input  logic [XLEN-1:0]              in_opb,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_result,
  output logic [TAG_W-1:0]             out_tag,
  output logic                         out_illegal,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int SH_W  = $clog2(XLEN);
  localparam int OCC_W = $clog2(STAGES+1);

  typedef enum logic [3:0] {
    FN_ADD  = 4'd0,
    FN_SUB  = 4'd1,
    FN_AND  = 4'd2,
    FN_SLT  = 4'd3,
    FN_SLTU = 4'd4,
    FN_OR   = 4'd5,
    FN_XOR  = 4'd6,
    FN_SRL  = 4'd7,
    FN_SLL  = 4'd8,
    FN_SRA  = 4'd9
  } func_e;

  logic [SH_W-1:0]  shamt;
  logic [XLEN-1:0]  alu_res;
  logic             alu_ill;

  always_comb begin
    shamt   = in_opb[SH_W-1:0];
    alu_res = '0;
    alu_ill = 1'b0;
    case (in_func)
      FN_ADD:  alu_res = in_opa + in_opb;
      FN_SUB:  alu_res = in_opa - in_opb;
      FN_AND:  alu_res = in_opa & in_opb;
      FN_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(in_opa) < $signed(in_opb)};
      FN_SLTU: alu_res = {{(XLEN-1){1'b0}}, in_opa < in_opb};
      FN_OR:   alu_res = in_opa | in_opb;
      FN_XOR:  alu_res = in_opa ^ in_opb;
      FN_SRL:  alu_res = in_opa >> shamt;
      FN_SLL:  alu_res = in_opa << shamt;
      FN_SRA:  alu_res = $unsigned($signed(in_opa) >>> shamt);
      default: alu_ill = 1'b1;
    endcase
  end

  logic [STAGES-1:0] stage_vld;

  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    logic             valid_q, valid_d;
    logic             ill_q, ill_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             src_valid, src_ill, ld;
    logic [XLEN-1:0]  src_res;
    logic [TAG_W-1:0] src_tag;

    assign stage_vld[k] = valid_q;
    // The ready chain is flattened: a stage can load whenever the output drains
    // or any stage from here to the output holds a bubble.
    assign ld = out_ready || !(&stage_vld[STAGES-1:k]);

    if (k == 0) begin : g_src
      always_comb begin
        src_valid = in_valid && in_ready;
        src_ill   = alu_ill;
        src_res   = alu_res;
        src_tag   = in_tag;
      end
    end else begin : g_src
      always_comb begin
        src_valid = gen_stage[k-1].valid_q;
        src_ill   = gen_stage[k-1].ill_q;
        src_res   = gen_stage[k-1].res_q;
        src_tag   = gen_stage[k-1].tag_q;
      end
    end

    always_comb begin
      valid_d = valid_q;
      ill_d   = ill_q;
      res_d   = res_q;
      tag_d   = tag_q;
      if (squash) begin
        valid_d = 1'b0;
      end else if (ld) begin
        valid_d = src_valid;
        if (src_valid) begin
          ill_d = src_ill;
          res_d = src_res;
          tag_d = src_tag;
        end
      end
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        valid_q <= 1'b0;
        ill_q   <= 1'b0;
        res_q   <= '0;
        tag_q   <= '0;
      end else begin
        valid_q <= valid_d;
        ill_q   <= ill_d;
        res_q   <= res_d;
        tag_q   <= tag_d;
      end
    end
  end

  always_comb begin
    in_ready    = !squash && gen_stage[0].ld;
    out_valid   = gen_stage[STAGES-1].valid_q;
    out_result  = gen_stage[STAGES-1].res_q;
    out_tag     = gen_stage[STAGES-1].tag_q;
    out_illegal = gen_stage[STAGES-1].ill_q;
  end

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             accept, retire;

  always_comb begin
    accept = in_valid && in_ready;
    retire = out_valid && out_ready && !squash;
    occ_d  = occ_q;
    if (squash) begin
      occ_d = '0;
    end else if (accept && !retire) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (retire && !accept) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: doc/alu_pipe_fu.md
Name: alu_pipe_fu

Overview:
- Parametrised, pipelined integer ALU functional unit; successor to the single-cycle combinational ALU.
- Takes pre-selected operands from the issue stage and carries a destination tag through STAGES register stages.
- Uses valid/ready handshakes on both sides with bubble collapse, plus a squash that flushes everything in flight.
- Sits between issue and the complete/CDB arbiter.

Parameters:
XLEN, 32, operand/result width (power of 2, >=8)
STAGES, 2, pipeline depth = issue-to-result latency in cycles (1..4)
TAG_W, 6, destination tag width (physical register index)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
squash  in  1  flush all in-flight ops (mispredict recovery)
in_valid  in  1  issue presents an op
in_ready  out  1  unit accepts op this cycle
in_func  in  4  op code: 0 ADD, 1 SUB, 2 AND, 3 SLT, 4 SLTU, 5 OR, 6 XOR, 7 SRL, 8 SLL, 9 SRA, 10-15 illegal
in_opa  in  XLEN  operand A
in_opb  in  XLEN  operand B
in_tag  in  TAG_W  destination tag
out_valid  out  1  result held at output
out_ready  in  1  complete stage takes result
out_result  out  XLEN  result
out_tag  out  TAG_W  tag of result
out_illegal  out  1  op code was 10-15; result forced to 0
occupancy  out  $clog2(STAGES+1)  count of valid stages

Behaviour:
- Reset (async, reset_n=0): all stage valid bits 0; out_valid=0, out_result=0, out_tag=0, out_illegal=0, occupancy=0. in_ready=1 immediately after release.
- Arithmetic is computed combinationally on the inputs and captured into stage 1; stages 2..STAGES are pure delay registers.
  - Shift amount is opb[$clog2(XLEN)-1:0].
  - SLT is signed; SLTU is unsigned. Both give a 0/1 result zero-extended to XLEN.
  - SRA sign-fills. ADD/SUB wrap modulo 2^XLEN.
- Output is the stage-STAGES register. Latency: an op accepted at edge N drives out_valid in the cycle after edge N+STAGES-1, i.e. STAGES cycles when no stall.
- Stage advance rule: stage k loads from k-1 when stage k is empty or stage k advances this cycle. The last stage advances when out_ready=1. Bubbles collapse.
- in_ready = !squash && (stage1 empty || stage1 advances). Must not depend combinationally on in_valid.
- Transfer occurs on an edge with in_valid && in_ready. A held op must not change in_* while in_ready=0; the unit does not latch it early.
- Output hold: while out_valid && !out_ready, out_result/out_tag/out_illegal stay stable. Stages behind it fill until full; then in_ready=0.
- Full throughput: one op per cycle when out_ready is held high.
- occupancy updates each edge: +1 for an accepted op, -1 for a retired op (out_valid && out_ready), no change when both occur.
- Squash (synchronous, priority over everything):
  - Every valid bit clears on the next edge and occupancy becomes 0.
  - in_valid is ignored that cycle; the output handshake that cycle is void, so the result is not retired and the consumer must not use it.
- Data registers need not clear on squash; only valid bits do. out_* data under out_valid=0 is don't-care except after reset.
- Reset asserted mid-operation drops all in-flight ops asynchronously.
- Illegal op: travels the pipe normally with out_illegal=1 and out_result=0.

Test Plan:
- Reset then ADD opa=0x7FFFFFFF, opb=1, tag=5, out_ready=1 -> out_valid exactly 2 cycles after the accept edge, out_result=0x80000000, out_tag=5, occupancy returns 0.
- Back-to-back SUB 3-5, SLT 0xFFFFFFFF<1, SLTU 0xFFFFFFFF<1, SRA 0x80000000>>>4, illegal func 12 -> results 0xFFFFFFFE, 1, 0, 0xF8000000, 0 with out_illegal=1, in order, one per cycle.
- out_ready=0 with 3 ops issued -> out_valid stays held; in_ready=0 once occupancy=2; releasing out_ready drains the results in order, with no loss or duplication.
- squash asserted with occupancy=2 and in_valid=1 -> next cycle out_valid=0, occupancy=0, squashed op never appears; an op issued the following cycle completes normally.
- reset_n pulsed low mid-stream, asynchronously and not clock-aligned -> outputs go to 0 immediately; first post-reset op has correct latency.
- STAGES=1, XLEN=64: SLL 1<<63 -> 0x8000000000000000 in 1 cycle; shift of 1 by opb=64 uses 6 bits -> shift by 0, result 1.
